// File: rtl/art_caption_uart.sv
// UART caption transmitter for the silicon-art tile: sends "SILICON ART v1\r\n" (8N1, LSB first)
// on a rising edge of start, optionally looping pass after pass.
module art_caption_uart #(
  parameter int DIV = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic start,
  input  logic loop,
  output logic tx,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [3:0]    byte_idx, byte_nx;
  logic          tx_nx, busy_nx, done_nx;
  logic          s1, s2, s3, rise, bit_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] rom(input logic [3:0] idx);
    case (idx)
      4'd0:    rom = 8'h53;
      4'd1:    rom = 8'h49;
      4'd2:    rom = 8'h4C;
      4'd3:    rom = 8'h49;
      4'd4:    rom = 8'h43;
      4'd5:    rom = 8'h4F;
      4'd6:    rom = 8'h4E;
      4'd7:    rom = 8'h20;
      4'd8:    rom = 8'h41;
      4'd9:    rom = 8'h52;
      4'd10:   rom = 8'h54;
      4'd11:   rom = 8'h20;
      4'd12:   rom = 8'h76;
      4'd13:   rom = 8'h31;
      4'd14:   rom = 8'h0D;
      default: rom = 8'h0A;
    endcase
  endfunction

  // NOTE: start is asynchronous; s1/s2 resolve metastability before anything decodes it,
  // and s3 only delays s2 so a held level yields a single rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= start;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign bit_end = (baud == BAUD_LAST);

  // NOTE: every output of this block gets a default before the case, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    done_nx  = 1'b0;
    if (!ena) begin
      state_nx = IDLE;
      baud_nx  = '0;
      bit_nx   = '0;
      byte_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = START;
            baud_nx  = '0;
            bit_nx   = '0;
            byte_nx  = '0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_nx  = '0;
            bit_nx   = '0;
            state_nx = DATA;
          end else begin
            baud_nx = baud + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_nx = '0;
            if (bit_idx == 3'd7) state_nx = STOP;
            else                 bit_nx   = bit_idx + 1'b1;
          end else begin
            baud_nx = baud + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_nx = '0;
            bit_nx  = '0;
            if (byte_idx != 4'd15) begin
              byte_nx  = byte_idx + 1'b1;
              state_nx = START;
            end else begin
              done_nx  = 1'b1;
              byte_nx  = '0;
              state_nx = loop ? START : IDLE;
            end
          end else begin
            baud_nx = baud + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Line level is decoded from the next state so tx, busy and the state change on one edge.
  always_comb begin
    cur_byte = rom(byte_nx);
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = cur_byte[bit_nx];
      default: tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud     <= baud_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_art_caption_uart.sv
// Scoreboard bench for art_caption_uart: UART receiver monitors decode tx frames and
// compare them against expected bytes queued by the stimulus (DIV=4 and DIV=7 instances).
module tb_art_caption_uart;

  logic clk;
  logic rst_n4, rst_n7, ena, loop, start4, start7;
  logic tx4, busy4, done4, tx7, busy7, done7;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dcount4 = 0;
  int dcount7 = 0;
  logic [7:0] exp4[$];
  logic [7:0] exp7[$];
  int fs4[$];

  art_caption_uart #(.DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .ena(ena), .start(start4), .loop(loop),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  art_caption_uart #(.DIV(7)) dut7 (
    .clk(clk), .rst_n(rst_n7), .ena(ena), .start(start7), .loop(1'b0),
    .tx(tx7), .busy(busy7), .done(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done4 === 1'b1) dcount4++;
    if (done7 === 1'b1) dcount7++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_caption(input bit sel);
    string s;
    s = "SILICON ART v1\r\n";
    for (int i = 0; i < 16; i++) begin
      if (sel) exp7.push_back(s[i]);
      else     exp4.push_back(s[i]);
    end
  endtask

  // Samples one 10-bit frame at successive negedges; every bit must hold for div cycles.
  task automatic rx_frame(input bit sel, input int div, output bit aborted,
                          output logic [7:0] data, output bit glitch, output bit stop_bit);
    logic v, first;
    aborted = 1'b0;
    glitch  = 1'b0;
    data    = '0;
    stop_bit = 1'b0;
    first   = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < div; k++) begin
        if (b > 0 || k > 0) @(negedge clk);
        if ((sel ? rst_n7 : rst_n4) !== 1'b1) begin
          aborted = 1'b1;
          return;
        end
        v = sel ? tx7 : tx4;
        if (k == 0) first = v;
        else if (v !== first) glitch = 1'b1;
      end
      if (b == 0 && first !== 1'b0) glitch = 1'b1;
      if (b >= 1 && b <= 8) data[b-1] = first;
      if (b == 9) stop_bit = first;
    end
  endtask

  task automatic score(input bit sel, input logic [7:0] d, input bit gl, input bit sb);
    logic [7:0] e;
    if ((sel ? exp7.size() : exp4.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL rx%0d_unexpected: got frame %0h expected no frame (cycle %0d)",
               sel ? 7 : 4, d, cyc);
    end else begin
      e = sel ? exp7.pop_front() : exp4.pop_front();
      check(sel ? "rx7_byte" : "rx4_byte", {24'd0, d}, {24'd0, e});
      check(sel ? "rx7_framing" : "rx4_framing", {30'd0, gl, sb}, 32'd1);
    end
  endtask

  initial begin : mon4
    bit ab, gl, sb;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rst_n4 === 1'b1 && tx4 === 1'b0) begin
        fs4.push_back(cyc);
        rx_frame(1'b0, 4, ab, d, gl, sb);
        if (!ab) score(1'b0, d, gl, sb);
      end
    end
  end

  initial begin : mon7
    bit ab, gl, sb;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rst_n7 === 1'b1 && tx7 === 1'b0) begin
        rx_frame(1'b1, 7, ab, d, gl, sb);
        if (!ab) score(1'b1, d, gl, sb);
      end
    end
  end

  task automatic wait_done(input bit sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel ? done7 : done4) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL done%0d_timeout: got no pulse expected pulse within %0d cycles",
               sel ? 7 : 4, budget);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin : stim
    int c0, f, at, d1, d2, dc;
    bit stuck;
    rst_n4 = 1'b0; rst_n7 = 1'b0;
    ena = 1'b1; loop = 1'b0; start4 = 1'b0; start7 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx4}, 32'd1);
    check("reset_busy", {31'd0, busy4}, 32'd0);
    check("reset_done", {31'd0, done4}, 32'd0);
    rst_n4 = 1'b1; rst_n7 = 1'b1;
    repeat (3) @(negedge clk);

    // Tests 1-2: single pass, latency and done timing.
    push_caption(1'b0);
    start4 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    repeat (2) @(negedge clk);
    check("t1_tx_before_3rd_edge", {31'd0, tx4}, 32'd1);
    @(negedge clk);
    check("t1_tx_falls_3rd_edge", {31'd0, tx4}, 32'd0);
    check("t1_busy_with_tx", {31'd0, busy4}, 32'd1);
    repeat (5) @(negedge clk);
    start4 = 1'b0;
    dc = dcount4;
    wait_done(1'b0, 700, at);
    check("t2_done_latency", at - f, 32'd640);
    check("t2_busy_drops", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    check("t2_done_one_cycle", {31'd0, done4}, 32'd0);
    stuck = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx4 !== 1'b1) stuck = 1'b1;
    end
    check("t2_tx_idle_high", {31'd0, stuck}, 32'd0);
    check("t2_done_count", dcount4 - dc, 32'd1);
    check("t2_all_bytes", exp4.size(), 32'd0);

    // Test 3: loop mode, back-to-back passes.
    loop = 1'b1;
    fs4.delete();
    push_caption(1'b0);
    push_caption(1'b0);
    start4 = 1'b1;
    wait_done(1'b0, 700, d1);
    loop = 1'b0;
    start4 = 1'b0;
    wait_done(1'b0, 700, d2);
    check("t3_done_period", d2 - d1, 32'd640);
    check("t3_frame_count", fs4.size(), 32'd32);
    if (fs4.size() >= 17) check("t3_wrap_gap", fs4[16] - fs4[15], 32'd40);
    repeat (20) @(negedge clk);
    check("t3_idle_after", {31'd0, busy4}, 32'd0);
    check("t3_all_bytes", exp4.size(), 32'd0);

    // Test 4: restart pulses and long hold while busy are ignored.
    dc = dcount4;
    push_caption(1'b0);
    start4 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    repeat (5) @(negedge clk);
    start4 = 1'b0;
    wait_until(f + 5 * 40 + 12);
    start4 = 1'b1;
    repeat (3) @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    start4 = 1'b1;
    repeat (2000) @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_single_done", dcount4 - dc, 32'd1);
    check("t4_busy_idle", {31'd0, busy4}, 32'd0);
    check("t4_all_bytes", exp4.size(), 32'd0);

    // Test 5: ena drop at bit 2 of byte 3 (0x49 reads 1,0 then line high -> 0xFD).
    dc = dcount4;
    exp4.push_back(8'h53);
    exp4.push_back(8'h49);
    exp4.push_back(8'h4C);
    exp4.push_back(8'hFD);
    start4 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    wait_until(f + 131);
    ena = 1'b0;
    @(negedge clk);
    check("t5_ena_tx", {31'd0, tx4}, 32'd1);
    check("t5_ena_busy", {31'd0, busy4}, 32'd0);
    check("t5_ena_done", {31'd0, done4}, 32'd0);
    repeat (10) @(negedge clk);
    ena = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_ena_rise_no_start", {31'd0, busy4}, 32'd0);
    ena = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    start4 = 1'b1;
    repeat (6) @(negedge clk);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_rise_while_disabled", {31'd0, busy4}, 32'd0);
    check("t5_no_done", dcount4 - dc, 32'd0);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    push_caption(1'b0);
    start4 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    repeat (3) @(negedge clk);
    check("t5_restart_tx", {31'd0, tx4}, 32'd0);
    start4 = 1'b0;
    wait_done(1'b0, 700, at);
    check("t5_restart_latency", at - f, 32'd640);

    // Test 6: async reset mid-frame on DIV=7, then a full pass.
    start7 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    wait_until(f + 30);
    @(posedge clk);
    #3;
    rst_n7 = 1'b0;
    #1;
    check("t6_async_tx", {31'd0, tx7}, 32'd1);
    check("t6_async_busy", {31'd0, busy7}, 32'd0);
    @(negedge clk);
    start7 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n7 = 1'b1;
    repeat (4) @(negedge clk);
    push_caption(1'b1);
    start7 = 1'b1;
    c0 = cyc;
    f = c0 + 3;
    repeat (3) @(negedge clk);
    check("t6_tx_falls", {31'd0, tx7}, 32'd0);
    check("t6_busy", {31'd0, busy7}, 32'd1);
    wait_done(1'b1, 1200, at);
    check("t6_pass_length", at - f, 32'd1120);
    start7 = 1'b0;

    repeat (20) @(negedge clk);
    check("final_exp4_empty", exp4.size(), 32'd0);
    check("final_exp7_empty", exp7.size(), 32'd0);
    check("final_done7_count", dcount7, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/art_caption_uart.md
Name: art_caption_uart

Overview:
- Output stage for the silicon-art tile. On request it transmits a fixed 16-byte ASCII caption over a single UART TX line.
- The caption is "SILICON ART v1" followed by CR LF.
- In the top level it drives uo_out[0] (tx), uo_out[1] (busy) and uo_out[2] (done). start comes from ui_in[0] and loop from ui_in[1].
- Logic stays small, so most of the tile area remains available for art.

Parameters:
- DIV, 87, clock cycles per UART bit (87 gives ~115200 baud at 10 MHz). Legal range 2..1023.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; low forces idle
- start  input  1  asynchronous request; a rising edge starts a message
- loop  input  1  when high at message end, the message restarts immediately
- tx  output  1  UART line, idle high, 8N1, LSB first
- busy  output  1  high while a message is in progress
- done  output  1  one-cycle pulse when the final stop bit of a pass completes

Behaviour:
- Reset is asynchronous and active-low. One clock, clk; all state is on its rising edge.
- Reset values: tx=1, busy=0, done=0. FSM=IDLE. All counters=0. Synchronizer flops=0.
- Reset asserted mid-frame: tx returns high immediately, with no partial-stop requirement.
- ROM holds 16 bytes, index 0..15: 53 49 4C 49 43 4F 4E 20 41 52 54 20 76 31 0D 0A (hex). It is combinational, indexed by a 4-bit byte counter.
- start synchronizer: 2 flops (s1, s2) plus edge register s3. rise = s2 & ~s3.
- Latency: FSM leaves IDLE on the edge where rise is sampled true. tx is registered low on the 3rd rising clk edge at which start is high.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. On rise & ena: go to START with byte_idx=0 and baud counter=0.
  - START: tx=0 for DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx=ROM[byte_idx][bit_idx] for DIV cycles per bit, bits 0..7. After bit 7, go to STOP.
  - STOP: tx=1 for DIV cycles. At the end of the period:
    - byte_idx<15: byte_idx+1, go to START.
    - byte_idx=15: done=1 for exactly that cycle. If loop=1, byte_idx wraps to 0 and the next state is START. Otherwise the next state is IDLE.
- busy is high in START/DATA/STOP and is registered with the state.
- Bit period is exactly DIV cycles. The baud counter counts 0..DIV-1 and is ceil(log2(DIV)) bits wide, with no off-by-one drift.
- Frame = 10*DIV cycles. Full pass = 160*DIV cycles. Loop passes run back-to-back with no extra idle cycle.
- start edges while busy are ignored and not queued.
- A start held high does not retrigger; a fresh rising edge is required.
- loop is sampled only at the end of byte 15's stop bit.
- ena low in any state: synchronously go to IDLE on the next edge, tx=1, busy=0, no done, counters cleared.
- ena rising does not start a message by itself.
- Simultaneous rise and ena low: stay IDLE.

Test Plan:
1. DIV=4. Reset, raise start. tx falls at the 3rd edge. The first frame over 40 cycles reads start 0, bits 1,1,0,0,1,0,1,0 (0x53), stop 1, each held 4 cycles. busy goes high with tx.
2. DIV=4, loop=0. Capture the full pass: 16 decoded bytes equal "SILICON ART v1\r\n". done pulses once, 640 cycles after tx first falls. busy drops on the same edge. tx stays 1 afterwards.
3. DIV=4, loop=1. After byte 0x0A's stop, the next start bit begins on the immediately following cycle and byte 0 is 0x53 again. done pulses every 640 cycles.
4. DIV=4. A second start pulse during byte 5, and start held high for 2000 cycles: exactly one pass is sent, with no retrigger.
5. DIV=4. Drop ena during DATA of byte 3: next edge tx=1, busy=0, no done. Re-raise ena with no start edge: stays idle. A new start edge restarts from byte 0.
6. DIV=7. Assert rst_n low asynchronously mid-frame, between clock edges: tx=1 and busy=0 before the next clk edge. After release, a normal pass is sent with 7-cycle bit periods (total 1120 cycles).
